// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory-side signal bundle for mem_port_arbiter
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [1:0]        i_access_size;
  logic [DATA_W-1:0] i_rdata;
  logic              i_done;

  logic              d_req;
  logic              d_rd_wr;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [1:0]        d_access_size;
  logic [DATA_W-1:0] d_rdata;
  logic              d_done;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;
  logic [1:0]        mem_access_size;
  logic              mem_rd_wr;
  logic              mem_enable;
  logic              mem_busy;

  // Arbiter side: serves the requesters and drives the memory port.
  modport slave (
    input  i_req, i_addr, i_access_size,
    output i_rdata, i_done,
    input  d_req, d_rd_wr, d_addr, d_wdata, d_access_size,
    output d_rdata, d_done,
    output mem_addr, mem_din, mem_access_size, mem_rd_wr, mem_enable,
    input  mem_dout, mem_busy
  );

  modport master (
    output i_req, i_addr, i_access_size,
    input  i_rdata, i_done,
    output d_req, d_rd_wr, d_addr, d_wdata, d_access_size,
    input  d_rdata, d_done,
    input  mem_addr, mem_din, mem_access_size, mem_rd_wr, mem_enable,
    output mem_dout, mem_busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between the I-fetch and data requesters
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;

  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

  state_t            state;
  owner_t            owner;
  logic [7:0]        starve_cnt;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_din_q;
  logic [1:0]        mem_size_q;
  logic              mem_rd_wr_q;
  logic              mem_enable_q;
  logic [DATA_W-1:0] i_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              i_done_q;
  logic              d_done_q;
  logic              grant_i;

  // D wins unless I has already watched STARVE_LIMIT consecutive D grants.
  assign grant_i = bus.i_req && (!bus.d_req || starve_cnt == STARVE_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      owner        <= OWN_NONE;
      starve_cnt   <= '0;
      mem_addr_q   <= '0;
      mem_din_q    <= '0;
      mem_size_q   <= '0;
      mem_rd_wr_q  <= 1'b1;
      mem_enable_q <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      i_done_q     <= 1'b0;
      d_done_q     <= 1'b0;
    end else begin
      i_done_q     <= 1'b0;
      d_done_q     <= 1'b0;
      mem_enable_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.i_req || bus.d_req) begin
            mem_enable_q <= 1'b1;
            state        <= S_ISSUE;
            if (grant_i) begin
              owner       <= OWN_I;
              mem_addr_q  <= bus.i_addr;
              mem_size_q  <= bus.i_access_size;
              mem_rd_wr_q <= 1'b1;
              starve_cnt  <= '0;
            end else begin
              owner       <= OWN_D;
              mem_addr_q  <= bus.d_addr;
              mem_din_q   <= bus.d_wdata;
              mem_size_q  <= bus.d_access_size;
              mem_rd_wr_q <= bus.d_rd_wr;
              if (!bus.i_req) begin
                starve_cnt <= '0;
              end else if (starve_cnt != STARVE_MAX) begin
                starve_cnt <= starve_cnt + 8'd1;
              end
            end
          end
        end
        S_ISSUE: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (!bus.mem_busy) begin
            if (owner == OWN_I) begin
              i_rdata_q <= bus.mem_dout;
              i_done_q  <= 1'b1;
            end else if (owner == OWN_D) begin
              if (mem_rd_wr_q) begin
                d_rdata_q <= bus.mem_dout;
              end
              d_done_q <= 1'b1;
            end
            owner <= OWN_NONE;
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.mem_addr        = mem_addr_q;
  assign bus.mem_din         = mem_din_q;
  assign bus.mem_access_size = mem_size_q;
  assign bus.mem_rd_wr       = mem_rd_wr_q;
  assign bus.mem_enable      = mem_enable_q;
  assign bus.i_rdata         = i_rdata_q;
  assign bus.i_done          = i_done_q;
  assign bus.d_rdata         = d_rdata_q;
  assign bus.d_done          = d_done_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized transaction-level check of mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 32;
  localparam int STARVE_LIMIT = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stimulus knobs
  bit run        = 1'b0;
  int i_rate     = 0;
  int d_rate     = 0;
  int busy_max   = 0;
  int busy_force = -1;

  // Transaction-level reference state
  bit          active  = 1'b0;
  bit          owner_i = 1'b0;
  bit          exp_en  = 1'b0;
  int          en_cyc  = 0;
  int          busy_n  = 0;
  int          done_at = 0;
  int          starve  = 0;
  logic [31:0] exp_dout  = '0;
  logic [31:0] m_i_rdata = '0;
  logic [31:0] m_d_rdata = '0;
  logic [31:0] g_addr = '0;
  logic [31:0] g_din  = '0;
  logic [1:0]  g_size = '0;
  logic        g_rd   = 1'b1;
  bit          dut_grant_log[$];

  task automatic new_i();
    bus.i_req         = 1'b1;
    bus.i_addr        = {4'h8, 26'($urandom), 2'b00};
    bus.i_access_size = 2'($urandom);
  endtask

  task automatic new_d();
    bus.d_req         = 1'b1;
    bus.d_addr        = {4'h9, 26'($urandom), 2'b00};
    bus.d_rd_wr       = 1'($urandom_range(0, 1));
    bus.d_wdata       = $urandom;
    bus.d_access_size = 2'($urandom);
  endtask

  task automatic model_step();
    bit exp_i_done;
    bit exp_d_done;
    bit gi;
    check_eq("mem_enable", 32'(bus.mem_enable), 32'(exp_en));
    if (exp_en) begin
      gi = bus.i_req && (!bus.d_req || starve == STARVE_LIMIT);
      if (gi) starve = 0;
      else if (bus.i_req) starve = (starve < STARVE_LIMIT) ? starve + 1 : starve;
      else starve = 0;
      active   = 1'b1;
      owner_i  = gi;
      en_cyc   = cyc;
      busy_n   = (busy_force >= 0) ? busy_force : int'($urandom_range(0, busy_max));
      done_at  = cyc + busy_n + 2;
      exp_dout = $urandom;
      g_addr   = gi ? bus.i_addr : bus.d_addr;
      g_size   = gi ? bus.i_access_size : bus.d_access_size;
      g_rd     = gi ? 1'b1 : bus.d_rd_wr;
      g_din    = bus.d_wdata;
      dut_grant_log.push_back(bus.mem_addr[31:28] == 4'h8);
    end
    if (active && cyc < done_at) begin
      check_eq("mem_addr", bus.mem_addr, g_addr);
      check_eq("mem_access_size", 32'(bus.mem_access_size), 32'(g_size));
      check_eq("mem_rd_wr", 32'(bus.mem_rd_wr), 32'(g_rd));
      if (!g_rd) check_eq("mem_din", bus.mem_din, g_din);
    end
    exp_i_done = active && cyc == done_at && owner_i;
    exp_d_done = active && cyc == done_at && !owner_i;
    if (active && cyc == done_at) begin
      if (owner_i) m_i_rdata = exp_dout;
      else if (g_rd) m_d_rdata = exp_dout;
      active = 1'b0;
    end
    check_eq("i_done", 32'(bus.i_done), 32'(exp_i_done));
    check_eq("d_done", 32'(bus.d_done), 32'(exp_d_done));
    check_eq("i_rdata", bus.i_rdata, m_i_rdata);
    check_eq("d_rdata", bus.d_rdata, m_d_rdata);

    // Memory: data valid for the whole transfer, busy only meaningful inside it.
    bus.mem_dout = active ? exp_dout : $urandom;
    if (active && cyc > en_cyc) bus.mem_busy = (cyc <= en_cyc + busy_n);
    else bus.mem_busy = 1'($urandom_range(0, 1));

    // Requesters hold until their own done, then may re-request in the done cycle.
    if (bus.i_req) begin
      if (exp_i_done) begin
        if (int'($urandom_range(0, 99)) < i_rate) new_i();
        else bus.i_req = 1'b0;
      end
    end else if (int'($urandom_range(0, 99)) < i_rate) begin
      new_i();
    end
    if (bus.d_req) begin
      if (exp_d_done) begin
        if (int'($urandom_range(0, 99)) < d_rate) new_d();
        else bus.d_req = 1'b0;
      end
    end else if (int'($urandom_range(0, 99)) < d_rate) begin
      new_d();
    end
    exp_en = !active && (bus.i_req || bus.d_req);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (run && !reset) model_step();
    end
  end

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_mem_enable"}, 32'(bus.mem_enable), 32'd0);
    check_eq({tag, "_mem_rd_wr"}, 32'(bus.mem_rd_wr), 32'd1);
    check_eq({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
    check_eq({tag, "_mem_din"}, bus.mem_din, 32'd0);
    check_eq({tag, "_mem_size"}, 32'(bus.mem_access_size), 32'd0);
    check_eq({tag, "_i_done"}, 32'(bus.i_done), 32'd0);
    check_eq({tag, "_d_done"}, 32'(bus.d_done), 32'd0);
    check_eq({tag, "_i_rdata"}, bus.i_rdata, 32'd0);
    check_eq({tag, "_d_rdata"}, bus.d_rdata, 32'd0);
  endtask

  bit [9:0] starve_pat = 10'b10000_10000;

  initial begin
    bus.i_req = 1'b0; bus.i_addr = '0; bus.i_access_size = '0;
    bus.d_req = 1'b0; bus.d_rd_wr = 1'b1; bus.d_addr = '0; bus.d_wdata = '0;
    bus.d_access_size = '0; bus.mem_dout = '0; bus.mem_busy = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(posedge clk);
    #2 reset = 1'b0;
    run = 1'b1;

    // Both requesters raised together and held, zero busy: starvation pattern.
    i_rate = 100; d_rate = 100; busy_max = 0;
    for (int k = 0; k < 300 && dut_grant_log.size() < 10; k++) @(posedge clk);
    if (dut_grant_log.size() < 10) check_eq("starve_timeout", 32'd0, 32'd1);
    else for (int k = 0; k < 10; k++) check_eq("starve_order", 32'(dut_grant_log[k]), 32'(starve_pat[k]));

    // I alone, back to back.
    d_rate = 0;
    repeat (40) @(posedge clk);

    // Random mix with variable memory latency.
    i_rate = 40; d_rate = 60; busy_max = 3;
    repeat (1500) @(posedge clk);

    // Reset in the WAIT state of a D read with busy held.
    i_rate = 0; d_rate = 0;
    for (int k = 0; k < 200 && (active || bus.i_req || bus.d_req); k++) @(posedge clk);
    if (active || bus.i_req || bus.d_req) check_eq("drain_timeout", 32'd0, 32'd1);
    busy_force = 6;
    @(posedge clk);
    #2;
    bus.d_req = 1'b1; bus.d_rd_wr = 1'b1; bus.d_addr = 32'h9002_0100; bus.d_access_size = 2'd0;
    for (int k = 0; k < 50 && !(active && cyc >= en_cyc + 3); k++) @(posedge clk);
    if (!(active && cyc >= en_cyc + 3)) check_eq("wait_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 check_reset_values("async_reset");
    active = 1'b0; starve = 0; exp_en = 1'b0;
    m_i_rdata = '0; m_d_rdata = '0; bus.mem_busy = 1'b0;
    @(posedge clk);
    #1 check_eq("reset_hold_d_done", 32'(bus.d_done), 32'd0);
    @(posedge clk);
    #2 reset = 1'b0;
    for (int k = 0; k < 100 && bus.d_req; k++) @(posedge clk);
    if (bus.d_req) check_eq("reissue_timeout", 32'd0, 32'd1);
    busy_force = -1;
    repeat (5) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    mismatched++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
